// File: rtl/block_ram_multi_word_dual_port_ctrl_if.sv
// ---------------------------------------------------------------------------
// block_ram_multi_word_dual_port_ctrl_if
//
// Bundles the access and status signals of the multi-word dual-port RAM
// controller. clk and rst_n stay outside as plain module ports.
//
//   clear_req          master -> slave  pulse, start a zero-fill
//   ready              slave  -> master 1 = accesses accepted
//   addr_x             master -> slave  row address, port x in {a, b}
//   rd_en_x            master -> slave  read request
//   wr_en_x            master -> slave  per-word write enables
//   wr_data_x          master -> slave  write word, broadcast to enabled words
//   rd_data_x          slave  -> master read row
//   rd_valid_x         slave  -> master one-cycle strobe per completed read
//   collision          slave  -> master pulse, both ports wrote the same word
// ---------------------------------------------------------------------------
interface block_ram_multi_word_dual_port_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 64,
    parameter int NUM_WORDS  = 288
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int RW = DATA_WIDTH * NUM_WORDS;

    logic                  clear_req;
    logic                  ready;
    logic [AW-1:0]         addr_a;
    logic                  rd_en_a;
    logic [NUM_WORDS-1:0]  wr_en_a;
    logic [DATA_WIDTH-1:0] wr_data_a;
    logic [RW-1:0]         rd_data_a;
    logic                  rd_valid_a;
    logic [AW-1:0]         addr_b;
    logic                  rd_en_b;
    logic [NUM_WORDS-1:0]  wr_en_b;
    logic [DATA_WIDTH-1:0] wr_data_b;
    logic [RW-1:0]         rd_data_b;
    logic                  rd_valid_b;
    logic                  collision;

    modport master (
        output clear_req,
        output addr_a, rd_en_a, wr_en_a, wr_data_a,
        output addr_b, rd_en_b, wr_en_b, wr_data_b,
        input  ready, collision,
        input  rd_data_a, rd_valid_a,
        input  rd_data_b, rd_valid_b
    );

    modport slave (
        input  clear_req,
        input  addr_a, rd_en_a, wr_en_a, wr_data_a,
        input  addr_b, rd_en_b, wr_en_b, wr_data_b,
        output ready, collision,
        output rd_data_a, rd_valid_a,
        output rd_data_b, rd_valid_b
    );
endinterface

// File: rtl/block_ram_multi_word_dual_port_ctrl.sv
// ---------------------------------------------------------------------------
// block_ram_multi_word_dual_port_ctrl
//
// True dual-port RAM whose rows hold NUM_WORDS words of DATA_WIDTH bits,
// with per-word write enables on both ports, a 1- or 2-stage registered read
// pipeline, read-valid strobes, a write-collision pulse and a clear sequencer
// that zero-fills every row after reset (CLEAR_EN=1) or on clear_req.
//
// Ports:
//   clk     rising-edge clock for all state
//   rst_n   asynchronous active-low reset (array contents are not reset)
//   bus     slave side of block_ram_multi_word_dual_port_ctrl_if
//
// Collision rules:
//   same port read+write : write-first per word (enabled words read new data)
//   cross port same row  : reader sees old data for words the other port writes
//   both ports same word : port A value is stored, collision pulses next cycle
// ---------------------------------------------------------------------------
module block_ram_multi_word_dual_port_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 64,
    parameter int NUM_WORDS  = 288,
    parameter int RD_LATENCY = 1,
    parameter int CLEAR_EN   = 1,
    parameter     RAM_STYLE  = "auto"
) (
    input  logic clk,
    input  logic rst_n,
    block_ram_multi_word_dual_port_ctrl_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int RW = DATA_WIDTH * NUM_WORDS;
    localparam logic [AW-1:0] LAST_ROW = AW'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam state_t RESET_STATE = (CLEAR_EN != 0) ? ST_CLEAR : ST_READY;

    // Port-indexed views of the bus so both ports share one generate body.
    // Index 0 is port A, index 1 is port B.
    logic [1:0][AW-1:0]         addr;
    logic [1:0]                 rd_en;
    logic [1:0][NUM_WORDS-1:0]  wr_en;
    logic [1:0][DATA_WIDTH-1:0] wr_data;
    logic [1:0][RW-1:0]         rd_merge;
    logic [1:0][RW-1:0]         rd_data_out;
    logic [1:0]                 rd_valid_out;

    assign addr[0]    = bus.addr_a;
    assign addr[1]    = bus.addr_b;
    assign rd_en[0]   = bus.rd_en_a;
    assign rd_en[1]   = bus.rd_en_b;
    assign wr_en[0]   = bus.wr_en_a;
    assign wr_en[1]   = bus.wr_en_b;
    assign wr_data[0] = bus.wr_data_a;
    assign wr_data[1] = bus.wr_data_b;

    state_t        state_reg;
    logic [AW-1:0] clr_cnt_reg;
    logic          ready_reg;
    logic          collision_reg;
    logic          clr_we;

    // The clear sequencer owns port A while clearing. Holding it off during
    // reset keeps the array untouched until rst_n is released.
    assign clr_we = (state_reg == ST_CLEAR) && rst_n;

    // -----------------------------------------------------------------------
    // Control FSM: clear sequencing, ready flag and collision pulse
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= RESET_STATE;
            clr_cnt_reg   <= '0;
            ready_reg     <= 1'b0;
            collision_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_CLEAR: begin
                    ready_reg <= 1'b0;
                    if (clr_cnt_reg == LAST_ROW) begin
                        state_reg   <= ST_READY;
                        clr_cnt_reg <= '0;
                        ready_reg   <= 1'b1;
                    end else begin
                        clr_cnt_reg <= clr_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    if (bus.clear_req) begin
                        state_reg   <= ST_CLEAR;
                        clr_cnt_reg <= '0;
                        ready_reg   <= 1'b0;
                    end else begin
                        ready_reg <= 1'b1;
                    end
                end
            endcase
            collision_reg <= ready_reg && (addr[0] == addr[1])
                             && (|(wr_en[0] & wr_en[1]));
        end
    end

    // -----------------------------------------------------------------------
    // Storage: one column array per word so each word has its own write
    // enable. Port B is written first so port A wins on a shared word.
    // The read side is merged with the same port's write data (write-first);
    // the other port's write lands after the read, so it returns old data.
    // -----------------------------------------------------------------------
    genvar gi;
    genvar gw;
    generate
        for (gw = 0; gw < NUM_WORDS; gw++) begin : g_word
            (* ram_style = RAM_STYLE *) logic [DATA_WIDTH-1:0] mem [DEPTH];

            always_ff @(posedge clk) begin
                if (clr_we) begin
                    mem[clr_cnt_reg] <= '0;
                end else if (ready_reg) begin
                    if (wr_en[1][gw]) mem[addr[1]] <= wr_data[1];
                    if (wr_en[0][gw]) mem[addr[0]] <= wr_data[0];
                end
            end

            for (gi = 0; gi < 2; gi++) begin : g_rd
                assign rd_merge[gi][gw*DATA_WIDTH +: DATA_WIDTH] =
                    wr_en[gi][gw] ? wr_data[gi] : mem[addr[gi]];
            end
        end

        // -------------------------------------------------------------------
        // Read pipeline per port. Data registers only load when a read
        // completes, so rd_data holds between reads and while not ready.
        // -------------------------------------------------------------------
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [RW-1:0] s1_data_reg;
            logic          s1_valid_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_valid_reg <= 1'b0;
                    s1_data_reg  <= '0;
                end else begin
                    s1_valid_reg <= ready_reg & rd_en[gi];
                    if (ready_reg & rd_en[gi]) begin
                        s1_data_reg <= rd_merge[gi];
                    end
                end
            end

            if (RD_LATENCY == 2) begin : g_lat2
                logic [RW-1:0] s2_data_reg;
                logic          s2_valid_reg;

                // Second stage is fed only by the first, so reads accepted
                // just before a clear still drain out.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        s2_valid_reg <= 1'b0;
                        s2_data_reg  <= '0;
                    end else begin
                        s2_valid_reg <= s1_valid_reg;
                        if (s1_valid_reg) begin
                            s2_data_reg <= s1_data_reg;
                        end
                    end
                end

                assign rd_data_out[gi]  = s2_data_reg;
                assign rd_valid_out[gi] = s2_valid_reg;
            end else begin : g_lat1
                assign rd_data_out[gi]  = s1_data_reg;
                assign rd_valid_out[gi] = s1_valid_reg;
            end
        end
    endgenerate

    assign bus.ready      = ready_reg;
    assign bus.collision  = collision_reg;
    assign bus.rd_data_a  = rd_data_out[0];
    assign bus.rd_valid_a = rd_valid_out[0];
    assign bus.rd_data_b  = rd_data_out[1];
    assign bus.rd_valid_b = rd_valid_out[1];

endmodule

// File: tb/tb_block_ram_multi_word_dual_port_ctrl.sv
// ---------------------------------------------------------------------------
// tb_block_ram_multi_word_dual_port_ctrl
//
// Directed scenarios plus a randomized phase. A row-level behavioural model
// (array of words, queues of pending read results) predicts every output;
// one compare process checks all outputs one time unit after each rising
// edge. Directed steps also carry hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_block_ram_multi_word_dual_port_ctrl;
    localparam int DW     = 8;
    localparam int DEPTH  = 64;
    localparam int NW     = 288;
    localparam int RD_LAT = 1;
    localparam int RW     = DW * NW;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    block_ram_multi_word_dual_port_ctrl_if #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_WORDS(NW)
    ) bus ();

    block_ram_multi_word_dual_port_ctrl #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_WORDS(NW),
        .RD_LATENCY(RD_LAT), .CLEAR_EN(1), .RAM_STYLE("auto")
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 0;

    // ---------------- behavioural model ----------------
    typedef struct {
        int            due;
        logic [RW-1:0] data;
    } rd_t;

    logic [DW-1:0] mmem [DEPTH][NW];
    rd_t           rq_a[$];
    rd_t           rq_b[$];
    int            clear_left;
    int            mcyc = 0;
    bit            exp_ready;
    bit            exp_coll;
    bit            exp_valid_a, exp_valid_b;
    logic [RW-1:0] exp_data_a, exp_data_b;

    function automatic logic [RW-1:0] read_row(input int a, input logic [NW-1:0] we,
                                               input logic [DW-1:0] wd);
        logic [RW-1:0] r;
        for (int w = 0; w < NW; w++) r[w*DW +: DW] = we[w] ? wd : mmem[a][w];
        return r;
    endfunction

    task automatic model_reset();
        rq_a.delete();
        rq_b.delete();
        exp_ready   = 0;
        exp_coll    = 0;
        exp_valid_a = 0;
        exp_valid_b = 0;
        exp_data_a  = '0;
        exp_data_b  = '0;
        clear_left  = DEPTH;
    endtask

    // Predicts outputs after the coming rising edge from the current inputs.
    task automatic model_step();
        rd_t e;
        bit  acc;
        if (!rst_n) begin
            model_reset();
            return;
        end
        mcyc++;
        acc      = exp_ready;
        exp_coll = 0;
        if (acc) begin
            if (bus.rd_en_a) begin
                e.due  = mcyc + RD_LAT - 1;
                e.data = read_row(int'(bus.addr_a), bus.wr_en_a, bus.wr_data_a);
                rq_a.push_back(e);
            end
            if (bus.rd_en_b) begin
                e.due  = mcyc + RD_LAT - 1;
                e.data = read_row(int'(bus.addr_b), bus.wr_en_b, bus.wr_data_b);
                rq_b.push_back(e);
            end
            exp_coll = (bus.addr_a == bus.addr_b) && ((bus.wr_en_a & bus.wr_en_b) != '0);
            for (int w = 0; w < NW; w++) begin
                if (bus.wr_en_b[w]) mmem[bus.addr_b][w] = bus.wr_data_b;
                if (bus.wr_en_a[w]) mmem[bus.addr_a][w] = bus.wr_data_a;
            end
        end
        if (clear_left > 0) begin
            for (int w = 0; w < NW; w++) mmem[DEPTH - clear_left][w] = '0;
            clear_left--;
            if (clear_left == 0) exp_ready = 1;
        end else if (bus.clear_req) begin
            clear_left = DEPTH;
            exp_ready  = 0;
        end else begin
            exp_ready = 1;
        end
        exp_valid_a = 0;
        exp_valid_b = 0;
        if (rq_a.size() > 0 && rq_a[0].due == mcyc) begin
            exp_valid_a = 1;
            exp_data_a  = rq_a[0].data;
            void'(rq_a.pop_front());
        end
        if (rq_b.size() > 0 && rq_b[0].due == mcyc) begin
            exp_valid_b = 1;
            exp_data_b  = rq_b[0].data;
            void'(rq_b.pop_front());
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk_bit(input string name, input logic got, input logic want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, got, want);
        end
    endtask

    task automatic chk_row(input string name, input logic [RW-1:0] got, input logic [RW-1:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            for (int w = 0; w < NW; w++) begin
                if (got[w*DW +: DW] !== want[w*DW +: DW]) begin
                    $display("FAIL %s @%0t: word %0d got %h expected %h", name, $time, w,
                             got[w*DW +: DW], want[w*DW +: DW]);
                    break;
                end
            end
        end
    endtask

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk_bit("ready",      bus.ready,      exp_ready);
            chk_bit("collision",  bus.collision,  exp_coll);
            chk_bit("rd_valid_a", bus.rd_valid_a, exp_valid_a);
            chk_bit("rd_valid_b", bus.rd_valid_b, exp_valid_b);
            chk_row("rd_data_a",  bus.rd_data_a,  exp_data_a);
            chk_row("rd_data_b",  bus.rd_data_b,  exp_data_b);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        bus.clear_req = 1'b0;
        bus.addr_a    = '0;
        bus.rd_en_a   = 1'b0;
        bus.wr_en_a   = '0;
        bus.wr_data_a = '0;
        bus.addr_b    = '0;
        bus.rd_en_b   = 1'b0;
        bus.wr_en_b   = '0;
        bus.wr_data_b = '0;
    endtask

    // Called at a falling edge with inputs set; returns at the next falling edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #2;
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < RD_LAT - 1; i++) begin
            idle();
            tick();
        end
    endtask

    function automatic logic [NW-1:0] rand_mask();
        logic [NW-1:0] m    = '0;
        int            mode = $urandom_range(0, 3);
        for (int w = 0; w < NW; w++) begin
            case (mode)
                1:       m[w] = 1'b1;
                2:       m[w] = ($urandom_range(0, 7) == 0);
                3:       m[w] = 1'($urandom_range(0, 1));
                default: m[w] = 1'b0;
            endcase
        end
        return m;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int n;
        int cnt_a, cnt_b, bad;
        idle();
        model_reset();
        #1 rst_n = 1'b0;
        chk_en = 1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) tick();
        lit("reset_ready", 32'(bus.ready), 0);
        lit("reset_valid", 32'(bus.rd_valid_a | bus.rd_valid_b), 0);

        // Release: ready must rise after exactly DEPTH edges.
        rst_n = 1'b1;
        n = 0;
        while (!bus.ready && n < 200) begin tick(); n++; end
        lit("ready_rise", n, DEPTH);
        $display("reset release: ready after %0d cycles", n);

        // Read every row on both ports; all zero, one strobe per read.
        cnt_a = 0; cnt_b = 0;
        for (int r = 0; r < DEPTH; r++) begin
            idle();
            bus.rd_en_a = 1'b1; bus.addr_a = 6'(r);
            bus.rd_en_b = 1'b1; bus.addr_b = 6'(DEPTH - 1 - r);
            tick();
            cnt_a += int'(bus.rd_valid_a); cnt_b += int'(bus.rd_valid_b);
        end
        for (int i = 0; i < RD_LAT; i++) begin
            idle(); tick();
            cnt_a += int'(bus.rd_valid_a); cnt_b += int'(bus.rd_valid_b);
        end
        lit("clr_rd_cnt_a", cnt_a, DEPTH);
        lit("clr_rd_cnt_b", cnt_b, DEPTH);
        $display("read all rows after clear: %0d/%0d strobes", cnt_a, cnt_b);

        // Write row 5 with 0x3C through A, read it through B.
        idle(); bus.addr_a = 6'd5; bus.wr_en_a = '1; bus.wr_data_a = 8'h3C; tick();
        idle(); bus.addr_b = 6'd5; bus.rd_en_b = 1'b1; tick(); drain();
        lit("w5_valid", 32'(bus.rd_valid_b), 1);
        lit("w5_word0", 32'(bus.rd_data_b[0 +: DW]), 32'h3C);
        lit("w5_word287", 32'(bus.rd_data_b[(NW-1)*DW +: DW]), 32'h3C);
        $display("write A row 5 = 3c, read B row 5 -> %h", bus.rd_data_b[0 +: DW]);

        // Same-port write-first and cross-port old data on row 7.
        idle();
        bus.addr_a = 6'd7; bus.wr_en_a[0] = 1'b1; bus.wr_data_a = 8'hAA; bus.rd_en_a = 1'b1;
        bus.addr_b = 6'd7; bus.rd_en_b = 1'b1;
        tick(); drain();
        lit("wf_a_word0", 32'(bus.rd_data_a[0 +: DW]), 32'hAA);
        lit("wf_a_word1", 32'(bus.rd_data_a[DW +: DW]), 32'h00);
        lit("wf_b_word0", 32'(bus.rd_data_b[0 +: DW]), 32'h00);
        $display("row 7 write-first: A word0 %h, B word0 %h", bus.rd_data_a[0 +: DW], bus.rd_data_b[0 +: DW]);

        // Both ports write word 2 of row 3: A wins, collision pulses once.
        idle();
        bus.addr_a = 6'd3; bus.wr_en_a[2] = 1'b1; bus.wr_data_a = 8'h11;
        bus.addr_b = 6'd3; bus.wr_en_b[2] = 1'b1; bus.wr_data_b = 8'h22;
        tick();
        lit("coll_pulse", 32'(bus.collision), 1);
        idle(); tick();
        lit("coll_clear", 32'(bus.collision), 0);
        idle(); bus.addr_a = 6'd3; bus.rd_en_a = 1'b1; tick(); drain();
        lit("coll_word2", 32'(bus.rd_data_a[2*DW +: DW]), 32'h11);
        $display("collision row 3 word 2: stored %h", bus.rd_data_a[2*DW +: DW]);

        // Disjoint words on the same row: no pulse, both stored.
        idle();
        bus.addr_a = 6'd3; bus.wr_en_a[2] = 1'b1; bus.wr_data_a = 8'h33;
        bus.addr_b = 6'd3; bus.wr_en_b[4] = 1'b1; bus.wr_data_b = 8'h44;
        tick();
        lit("nocoll_pulse", 32'(bus.collision), 0);
        idle(); bus.addr_b = 6'd3; bus.rd_en_b = 1'b1; tick(); drain();
        lit("nocoll_word2", 32'(bus.rd_data_b[2*DW +: DW]), 32'h33);
        lit("nocoll_word4", 32'(bus.rd_data_b[4*DW +: DW]), 32'h44);
        $display("disjoint words row 3: %h %h", bus.rd_data_b[2*DW +: DW], bus.rd_data_b[4*DW +: DW]);

        // Fill every row with 0xFF, then clear on request.
        for (int r = 0; r < DEPTH / 2; r++) begin
            idle();
            bus.addr_a = 6'(r);             bus.wr_en_a = '1; bus.wr_data_a = 8'hFF;
            bus.addr_b = 6'(r + DEPTH / 2); bus.wr_en_b = '1; bus.wr_data_b = 8'hFF;
            tick();
        end
        idle(); bus.clear_req = 1'b1; tick();
        n = 0; bad = 0;
        while (!bus.ready && n < 200) begin
            bad += int'(bus.rd_valid_a) + int'(bus.rd_valid_b);
            idle();
            bus.rd_en_a = 1'b1; bus.addr_a = 6'($urandom_range(0, DEPTH - 1));
            bus.rd_en_b = 1'b1; bus.addr_b = 6'($urandom_range(0, DEPTH - 1));
            bus.wr_en_a = '1;   bus.wr_data_a = 8'h5A;
            tick(); n++;
        end
        lit("clr_req_cycles", n, DEPTH);
        lit("clr_req_valids", bad, 0);
        for (int r = 0; r < DEPTH; r++) begin
            idle(); bus.rd_en_a = 1'b1; bus.addr_a = 6'(r); tick();
        end
        drain();
        lit("clr_req_row63", 32'(bus.rd_data_a[0 +: DW]), 32'h00);
        $display("clear_req: not ready for %0d cycles, rows re-read as zero", n);

        // Randomized traffic, occasional clear requests.
        for (int i = 0; i < 1500; i++) begin
            idle();
            bus.clear_req = ($urandom_range(0, 299) == 0);
            bus.addr_a    = 6'($urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, DEPTH - 1));
            bus.addr_b    = 6'($urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, DEPTH - 1));
            bus.rd_en_a   = 1'($urandom_range(0, 1));
            bus.rd_en_b   = 1'($urandom_range(0, 1));
            bus.wr_en_a   = rand_mask();
            bus.wr_en_b   = rand_mask();
            bus.wr_data_a = 8'($urandom);
            bus.wr_data_b = 8'($urandom);
            tick();
        end
        $display("random phase: 1500 cycles applied");

        // Make sure the controller is ready before the reset tests.
        n = 0;
        while (!bus.ready && n < 200) begin idle(); tick(); n++; end

        // Reset with a read just issued: outputs drop at once.
        idle(); bus.rd_en_a = 1'b1; bus.addr_a = 6'd3; tick();
        idle(); rst_n = 1'b0;
        #1;
        lit("rst_ready", 32'(bus.ready), 0);
        lit("rst_valid", 32'(bus.rd_valid_a), 0);
        lit("rst_data",  32'(bus.rd_data_a[2*DW +: DW]), 0);
        bad = 0;
        for (int i = 0; i < 3; i++) begin tick(); bad += int'(bus.rd_valid_a); end
        rst_n = 1'b1;
        n = 0;
        while (!bus.ready && n < 200) begin tick(); n++; bad += int'(bus.rd_valid_a); end
        lit("rst_read_ready_rise", n, DEPTH);
        lit("rst_read_valids", bad, 0);
        $display("reset during read: ready after %0d cycles", n);

        // Reset in the middle of a requested clear; full clear reruns.
        idle(); bus.clear_req = 1'b1; tick();
        idle();
        for (int i = 0; i < 10; i++) tick();
        rst_n = 1'b0;
        bus.rd_en_a = 1'b1; bus.rd_en_b = 1'b1;
        tick(); tick();
        idle();
        rst_n = 1'b1;
        n = 0;
        while (!bus.ready && n < 200) begin tick(); n++; end
        lit("rst_clr_ready_rise", n, DEPTH);
        for (int r = 0; r < DEPTH; r++) begin
            idle(); bus.rd_en_b = 1'b1; bus.addr_b = 6'(r); tick();
        end
        idle(); tick(); tick();
        $display("reset mid-clear: ready after %0d cycles", n);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
